// File: rtl/flit_rank_stage.sv
// flit_rank_stage: registers four incoming flit headers, sorted by priority, in front of the BLESS port allocator.
// Optional golden-epoch prioritisation is compiled in when GOLDEN_PRIO_EN is defined.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module flit_rank_stage #(
    parameter int AGE_W   = 8,
    parameter int ID_W    = 6,
    parameter int EPOCH_W = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   valid_in,
    input  logic [4*AGE_W-1:0]           age_in,
    input  logic [4*ID_W-1:0]            src_in,
    input  logic [4*(`NUM_PORT-1)-1:0]   ppv_in,
    output logic                         valid_0,
    output logic                         valid_1,
    output logic                         valid_2,
    output logic                         valid_3,
    output logic [`NUM_PORT-2:0]         ppv_0,
    output logic [`NUM_PORT-2:0]         ppv_1,
    output logic [`NUM_PORT-2:0]         ppv_2,
    output logic [`NUM_PORT-2:0]         ppv_3,
    output logic [1:0]                   rank_ch_0,
    output logic [1:0]                   rank_ch_1,
    output logic [1:0]                   rank_ch_2,
    output logic [1:0]                   rank_ch_3,
    output logic [AGE_W-1:0]             age_0,
    output logic [AGE_W-1:0]             age_1,
    output logic [AGE_W-1:0]             age_2,
    output logic [AGE_W-1:0]             age_3,
    output logic [`PC_INDEX_WIDTH-1:0]   numFlit_out,
    output logic [ID_W-1:0]              golden_id
);

    localparam int PW    = `NUM_PORT - 1;
    localparam int KEY_W = AGE_W + 4;

    logic [3:0]      gold;
    logic [ID_W-1:0] gid_q;

`ifdef GOLDEN_PRIO_EN
    logic [EPOCH_W-1:0] epoch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_q <= '0;
            gid_q   <= '0;
        end else begin
            epoch_q <= epoch_q + EPOCH_W'(1);
            if (epoch_q == '1)
                gid_q <= gid_q + ID_W'(1);
        end
    end

    always_comb begin
        gold = '0;
        for (int unsigned c = 0; c < 4; c++)
            gold[c] = valid_in[c] && (src_in[c*ID_W +: ID_W] == gid_q);
    end
`else
    logic               unused_src;
    logic [EPOCH_W-1:0] unused_epoch;

    assign gid_q        = '0;
    assign gold         = '0;
    assign unused_src   = ^src_in;
    assign unused_epoch = '0;
`endif

    // Key {golden, valid, age, ~ch}: the channel term makes every key unique,
    // so the sort is a strict total order and the low bits recover the channel.
    logic [KEY_W-1:0] key [4];
    logic [KEY_W-1:0] s1  [4];
    logic [KEY_W-1:0] s2  [4];
    logic [KEY_W-1:0] srt [4];

    always_comb begin
        for (int unsigned c = 0; c < 4; c++)
            key[c] = {gold[c], valid_in[c], age_in[c*AGE_W +: AGE_W], ~2'(c)};
    end

    function automatic logic [2*KEY_W-1:0] cx(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return (a >= b) ? {a, b} : {b, a};
    endfunction

    always_comb begin
        {s1[0], s1[1]}   = cx(key[0], key[1]);
        {s1[2], s1[3]}   = cx(key[2], key[3]);
        {s2[0], s2[2]}   = cx(s1[0], s1[2]);
        {s2[1], s2[3]}   = cx(s1[1], s1[3]);
        srt[0]           = s2[0];
        srt[3]           = s2[3];
        {srt[1], srt[2]} = cx(s2[1], s2[2]);
    end

    logic                       nxt_valid [4];
    logic [1:0]                 sel_ch    [4];
    logic [1:0]                 nxt_ch    [4];
    logic [PW-1:0]              nxt_ppv   [4];
    logic [AGE_W-1:0]           sel_age   [4];
    logic [AGE_W-1:0]           nxt_age   [4];
    logic [`PC_INDEX_WIDTH-1:0] nxt_num;

    always_comb begin
        nxt_num = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            nxt_valid[k] = srt[k][KEY_W-2];
            sel_ch[k]    = ~srt[k][1:0];
            sel_age[k]   = srt[k][2 +: AGE_W];
            nxt_ch[k]    = nxt_valid[k] ? sel_ch[k] : '0;
            nxt_ppv[k]   = nxt_valid[k] ? ppv_in[sel_ch[k]*PW +: PW] : '0;
            if (!nxt_valid[k])
                nxt_age[k] = '0;
            else if (sel_age[k] == '1)
                nxt_age[k] = '1;
            else
                nxt_age[k] = sel_age[k] + AGE_W'(1);
            nxt_num = nxt_num + `PC_INDEX_WIDTH'(valid_in[k]);
        end
    end

    logic                       valid_q [4];
    logic [1:0]                 ch_q    [4];
    logic [PW-1:0]              ppv_q   [4];
    logic [AGE_W-1:0]           age_q   [4];
    logic [`PC_INDEX_WIDTH-1:0] num_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < 4; k++) begin
                valid_q[k] <= 1'b0;
                ch_q[k]    <= '0;
                ppv_q[k]   <= '0;
                age_q[k]   <= '0;
            end
            num_q <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                valid_q[k] <= nxt_valid[k];
                ch_q[k]    <= nxt_ch[k];
                ppv_q[k]   <= nxt_ppv[k];
                age_q[k]   <= nxt_age[k];
            end
            num_q <= nxt_num;
        end
    end

    assign valid_0     = valid_q[0];
    assign valid_1     = valid_q[1];
    assign valid_2     = valid_q[2];
    assign valid_3     = valid_q[3];
    assign ppv_0       = ppv_q[0];
    assign ppv_1       = ppv_q[1];
    assign ppv_2       = ppv_q[2];
    assign ppv_3       = ppv_q[3];
    assign rank_ch_0   = ch_q[0];
    assign rank_ch_1   = ch_q[1];
    assign rank_ch_2   = ch_q[2];
    assign rank_ch_3   = ch_q[3];
    assign age_0       = age_q[0];
    assign age_1       = age_q[1];
    assign age_2       = age_q[2];
    assign age_3       = age_q[3];
    assign numFlit_out = num_q;
    assign golden_id   = gid_q;

endmodule
